// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Serial pattern detector. Takes one qualified bit per clock, compares the
//   last N accepted bits (first-received bit in the MSB) with a programmable
//   pattern, and emits a one-cycle match pulse plus a saturating match count.
//   Overlapping or non-overlapping matching is selected at run time.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (beats load and valid)
//   a          in   serial data bit
//   valid      in   a is accepted only when high
//   load       in   load pattern_in; clears window, fill and count (beats valid)
//   pattern_in in   [N-1:0] pattern to load
//   overlap    in   1 = overlapping matches, 0 = each match needs N fresh bits
//   y          out  one-cycle match pulse, registered on the completing edge
//   count      out  [CNT_W-1:0] matches since reset/load, saturating
//   sat        out  high while count is all ones
module seq_pattern_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             valid,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             overlap,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]     window_q, window_d;
  logic [N-1:0]     pattern_q, pattern_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             y_q, y_d;

  logic [N-1:0]     window_nxt;
  logic [FW-1:0]    fill_nxt;
  logic             match;

  // Window and fill as they would be after accepting the current bit.
  assign window_nxt = {window_q[N-2:0], a};
  assign fill_nxt   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign match      = valid && !load && (fill_nxt == FILL_FULL) &&
                      (window_nxt == pattern_q);

  always_comb begin
    window_d  = window_q;
    pattern_d = pattern_q;
    fill_d    = fill_q;
    count_d   = count_q;
    y_d       = 1'b0;
    if (load) begin
      // The bit presented with load is dropped.
      pattern_d = pattern_in;
      window_d  = '0;
      fill_d    = '0;
      count_d   = '0;
    end else if (valid) begin
      window_d = window_nxt;
      fill_d   = fill_nxt;
      if (match) begin
        y_d = 1'b1;
        if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
        // Non-overlap: restart filling so the next match needs N new bits.
        if (!overlap) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_q  <= '0;
      pattern_q <= PATTERN;
      fill_q    <= '0;
      count_q   <= '0;
      y_q       <= 1'b0;
    end else begin
      window_q  <= window_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      y_q       <= y_d;
    end
  end

  assign y     = y_q;
  assign count = count_q;
  assign sat   = (count_q == {CNT_W{1'b1}});

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       valid = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       overlap = 1'b1;

  logic       y, sat;
  logic [7:0] count;
  logic       y_s, sat_s;
  logic [1:0] count_s;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a(a), .valid(valid), .load(load),
    .pattern_in(pattern_in), .overlap(overlap),
    .y(y), .count(count), .sat(sat)
  );

  // Narrow-counter instance for saturation; shares all inputs.
  seq_pattern_detector #(.N(4), .PATTERN(4'b1101), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .a(a), .valid(valid), .load(load),
    .pattern_in(pattern_in), .overlap(overlap),
    .y(y_s), .count(count_s), .sat(sat_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0; load = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Send n bits (bits[n-1] first) with valid=1, checking y after each edge
  // against the matching bit of exp_y.
  task automatic stream(input string tag, input logic [31:0] bits,
                        input logic [31:0] exp_y, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      a = bits[i]; valid = 1'b1;
      tick();
      chk($sformatf("%s_y_bit%0d", tag, n - i), {31'b0, y}, {31'b0, exp_y[i]});
    end
    valid = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_y", {31'b0, y}, 0);
    chk("rst_count", {24'b0, count}, 0);
    chk("rst_sat", {31'b0, sat}, 0);
    chk("rst_sat_s", {31'b0, sat_s}, 0);
    reset = 1'b0;

    // Overlapping: 1101101 -> matches at bits 4 and 7
    overlap = 1'b1;
    stream("ovl", 32'b1101101, 32'b0001001, 7);
    chk("ovl_count", {24'b0, count}, 2);

    // Non-overlapping: same stream -> match at bit 4 only
    do_reset();
    overlap = 1'b0;
    stream("novl", 32'b1101101, 32'b0001000, 7);
    chk("novl_count", {24'b0, count}, 1);

    // Valid gaps between bits 2 and 3
    do_reset();
    overlap = 1'b1;
    stream("gap_a", 32'b11, 32'b00, 2);
    for (int i = 0; i < 3; i++) begin
      a = i[0]; valid = 1'b0;
      tick();
      chk("gap_idle_y", {31'b0, y}, 0);
    end
    stream("gap_b", 32'b01, 32'b01, 2);
    chk("gap_count", {24'b0, count}, 1);

    // Two matches, then load 0110 (valid=1 a=1 on the load cycle, discarded)
    do_reset();
    stream("pre", 32'b11011101, 32'b00010001, 8);
    chk("pre_count", {24'b0, count}, 2);
    load = 1'b1; pattern_in = 4'b0110; a = 1'b1; valid = 1'b1;
    tick();
    load = 1'b0; valid = 1'b0;
    chk("load_count", {24'b0, count}, 0);
    chk("load_y", {31'b0, y}, 0);
    stream("ld_old", 32'b1101, 32'b0000, 4);
    stream("ld_new", 32'b0110, 32'b0001, 4);
    chk("ld_count", {24'b0, count}, 1);

    // Saturation on the 2-bit counter; reset restores pattern 1101
    do_reset();
    overlap = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      stream("satr", 32'b1101, 32'b0001, 4);
      chk("sat_y_s", {31'b0, y_s}, 1);
      chk("sat_count_s", {30'b0, count_s}, (m < 3) ? m : 3);
      chk("sat_flag_s", {31'b0, sat_s}, (m >= 3) ? 1 : 0);
    end
    chk("sat_count_wide", {24'b0, count}, 5);
    chk("sat_flag_wide", {31'b0, sat}, 0);

    // Reset mid-sequence (with valid=1 a=1 held during reset)
    do_reset();
    stream("mid", 32'b110, 32'b000, 3);
    reset = 1'b1; a = 1'b1; valid = 1'b1;
    tick();
    reset = 1'b0; valid = 1'b0;
    chk("mid_rst_y", {31'b0, y}, 0);
    chk("mid_rst_count", {24'b0, count}, 0);
    chk("mid_rst_sat_s", {31'b0, sat_s}, 0);
    stream("post", 32'b1, 32'b0, 1);
    stream("post2", 32'b1101, 32'b0001, 4);
    chk("post_count", {24'b0, count}, 1);
    tick();
    chk("post_y_drop", {31'b0, y}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
